fft_frame_feeder: RTL and testbench
===================================

// Module: fft_frame_feeder
// PURPOSE
//  Source side of the Top_FFT serial input port. Accepts complex samples from upstream over a
//  valid/ready stream and buffers them in a ping-pong RAM. Once a full NFFT-sample frame is
//  buffered, it emits that frame to Top_FFT as a start_FFT pulse plus NFFT gap-free samples.
//  Sits between the acquisition path and Top_FFT; replaces the file-driven stimulus.
// PARAMETERS
//  INTEGER_SIZE  16   integer bits of fixed-point sample
//  FRACT_SIZE    16   fraction bits; DATA_WIDTH = INTEGER_SIZE+FRACT_SIZE
//  NFFT          128  frame length; power of 2, >= 4; ADDR_W = $clog2(NFFT)
//  FRAME_GAP     0    idle cycles forced between consecutive frames (0 = back-to-back)
// PORTS
//  clk          in   1           single clock, rising edge
//  rst          in   1           synchronous, active-high reset
//  in_valid     in   1           upstream sample valid
//  in_ready     out  1           feeder can accept a sample this cycle
//  in_r         in   DATA_WIDTH  signed real part
//  in_i         in   DATA_WIDTH  signed imaginary part
//  start_FFT    out  1           one-cycle pulse, coincident with sample 0 of a frame
//  serial_in_r  out  DATA_WIDTH  real sample to Top_FFT
//  serial_in_i  out  DATA_WIDTH  imaginary sample to Top_FFT
//  busy         out  1           high during every cycle that a frame sample is driven
//  frames_sent  out  16          count of completed frames; wraps at 2^16
// BEHAVIOUR
//  Reset: in_ready=1, start_FFT=0, serial_in_r/i=0, busy=0, frames_sent=0.
//   Both banks empty; wr_bank=rd_bank=0; counters 0.
//  Write side:
//   - in_ready = !full[wr_bank]. A transfer occurs on in_valid && in_ready.
//   - Each transfer writes RAM[wr_bank][wr_cnt] and increments wr_cnt.
//   - On the transfer with wr_cnt==NFFT-1: set full[wr_bank], toggle wr_bank, clear wr_cnt.
//   - Stalls in in_valid are tolerated and never appear on the output side.
//  Read FSM, states IDLE/SEND/GAP:
//   - IDLE: if full[rd_bank], issue the read of addr 0 and go to SEND.
//   - SEND: issue the read of rd_cnt+1 each cycle.
//   - RAM read is synchronous (1 cycle), so all outputs are registered.
//   - Latency: if the last write of a frame occurs at edge E, start_FFT and sample 0 are
//     valid after edge E+2. Sample k is valid after edge E+2+k.
//   - full[rd_bank] clears on the edge that drives sample NFFT-1. On the same edge rd_bank
//     toggles and frames_sent increments.
//   - After sample NFFT-1: if FRAME_GAP==0 and the other bank is full, sample 0 of the next
//     frame (with start_FFT) follows in the very next cycle. Otherwise go to GAP for
//     FRAME_GAP cycles, then IDLE.
//  When not driving a sample: serial_in_r/i=0, start_FFT=0, busy=0.
//  Simultaneous write-fill of one bank and read-free of the other in the same cycle: both
//   update independently; no priority needed.
//  Both banks full: in_ready=0 until the draining frame frees its bank; no sample is lost
//   or duplicated.
//  Reset mid-operation: takes effect at the next edge. The in-flight frame is truncated
//   (no further samples) and partial/full banks are discarded. Outputs return to reset
//   values on that edge.
//  No arithmetic on data: samples pass bit-exact; fixed-point format is the caller's.
// STRUCTURE
//  Shared header fft_params.vh: INTEGER_SIZE, FRACT_SIZE, DATA_WIDTH, NFFT, ADDR_W
//   (also used by Top_FFT).
//  Sub-module fft_feed_bank_ram:
//   - simple dual-port RAM, depth 2*NFFT, width 2*DATA_WIDTH;
//   - address = {bank, index}; write port and synchronous read port.
//  Top level contains write counter/bank flags, read FSM and output registers.
// TESTING
//  1. Reset; 128 continuous samples, r=k, i=-k -> in_ready stays 1; one start_FFT 2 cycles
//     after last accept; serial_in_r=0..127 on consecutive cycles; then zeros; frames_sent=1.
//  2. Two frames back-to-back, FRAME_GAP=0 -> second start_FFT in the cycle after sample 127;
//     256 contiguous busy cycles; frames_sent=2.
//  3. Three frames offered at full rate -> in_ready low from the accept ending frame 2 until
//     frame 1 sample 127 is driven; all 384 samples out in order exactly once.
//  4. in_valid toggling 1/0 every cycle -> output frame still 128 gap-free samples with
//     correct values.
//  5. rst pulsed while sample 60 is driven -> next edge start_FFT=0, serial=0, busy=0,
//     in_ready=1; a following frame is emitted from sample 0 with correct data.
//  6. FRAME_GAP=3, two queued frames -> exactly 3 zero/non-busy cycles between sample 127
//     and the next start_FFT.

Source files
------------

// File: rtl/fft_frame_feeder_pkg.sv
// rtl/fft_frame_feeder_pkg.sv - shared types and helpers for the FFT frame feeder
package fft_frame_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } rd_state_t;

  // Width of the inter-frame gap counter; a zero or one cycle gap still needs one bit.
  function automatic int gap_width(input int gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

endpackage

// File: rtl/fft_feed_bank_ram.sv
// rtl/fft_feed_bank_ram.sv - ping-pong sample RAM, address {bank, index}, synchronous read
module fft_feed_bank_ram #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - buffers NFFT-sample frames in a ping-pong RAM and streams them
// gap-free to Top_FFT with a start_FFT pulse on sample 0
module fft_frame_feeder
  import fft_frame_feeder_pkg::*;
#(
  parameter int INTEGER_SIZE = 16,
  parameter int FRACT_SIZE   = 16,
  parameter int NFFT         = 128,
  parameter int FRAME_GAP    = 0,
  localparam int DATA_WIDTH  = INTEGER_SIZE + FRACT_SIZE,
  localparam int ADDR_W      = $clog2(NFFT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  start_FFT,
  output logic [DATA_WIDTH-1:0] serial_in_r,
  output logic [DATA_WIDTH-1:0] serial_in_i,
  output logic                  busy,
  output logic [15:0]           frames_sent
);

  localparam int GAP_W = gap_width(FRAME_GAP);

  rd_state_t               state;
  logic                    wr_bank;
  logic                    rd_bank;
  logic [1:0]              full;
  logic [ADDR_W-1:0]       wr_cnt;
  logic [ADDR_W-1:0]       rd_cnt;
  logic [GAP_W-1:0]        gap_cnt;
  logic [ADDR_W:0]         rd_addr;
  logic [2*DATA_WIDTH-1:0] rd_data;
  logic                    wr_fire;
  logic                    wr_done;
  logic                    rd_last;
  logic                    gap_last;
  logic                    kick;

  assign in_ready = !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_done  = wr_fire && (wr_cnt == ADDR_W'(NFFT - 1));
  assign rd_last  = (state == SEND) && (rd_cnt == ADDR_W'(NFFT - 1));
  assign gap_last = (state == GAP) && (32'(gap_cnt) == 32'(FRAME_GAP - 1));
  // The last gap cycle doubles as IDLE so the gap is exactly FRAME_GAP cycles long.
  assign kick     = ((state == IDLE) || gap_last) && full[rd_bank];

  always_comb begin
    rd_addr = {rd_bank, ADDR_W'(0)};
    if (state == SEND) begin
      // On the final sample, prefetch sample 0 of the other bank for a back-to-back frame.
      rd_addr = rd_last ? {!rd_bank, ADDR_W'(0)} : {rd_bank, rd_cnt + ADDR_W'(1)};
    end
  end

  fft_feed_bank_ram #(
    .WIDTH  (2 * DATA_WIDTH),
    .ADDR_W (ADDR_W + 1)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank, wr_cnt}),
    .wr_data ({in_r, in_i}),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Fill and drain always target different banks, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      full    <= '0;
    end else begin
      if (wr_fire) wr_cnt <= wr_done ? '0 : wr_cnt + ADDR_W'(1);
      if (wr_done) begin
        wr_bank       <= !wr_bank;
        full[wr_bank] <= 1'b1;
      end
      if (rd_last) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      rd_cnt      <= '0;
      gap_cnt     <= '0;
      start_FFT   <= 1'b0;
      serial_in_r <= '0;
      serial_in_i <= '0;
      busy        <= 1'b0;
      frames_sent <= '0;
    end else begin
      if (state == SEND) begin
        {serial_in_r, serial_in_i} <= rd_data;
        start_FFT                  <= (rd_cnt == '0);
        busy                       <= 1'b1;
      end else begin
        serial_in_r <= '0;
        serial_in_i <= '0;
        start_FFT   <= 1'b0;
        busy        <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (kick) begin
            state  <= SEND;
            rd_cnt <= '0;
          end
        end
        SEND: begin
          if (rd_last) begin
            rd_bank     <= !rd_bank;
            frames_sent <= frames_sent + 16'd1;
            rd_cnt      <= '0;
            gap_cnt     <= '0;
            if (FRAME_GAP == 0 && full[!rd_bank]) state <= SEND;
            else if (FRAME_GAP == 0)               state <= IDLE;
            else                                   state <= GAP;
          end else begin
            rd_cnt <= rd_cnt + ADDR_W'(1);
          end
        end
        GAP: begin
          if (gap_last) begin
            state  <= kick ? SEND : IDLE;
            rd_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - scoreboard bench for fft_frame_feeder (FRAME_GAP 0 and 3)
module tb_fft_frame_feeder;
  localparam int NFFT = 128;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v0  = 1'b0;
  logic          v3  = 1'b0;
  logic [DW-1:0] in_r = '0;
  logic [DW-1:0] in_i = '0;
  logic          rdy0, st0, b0, rdy3, st3, b3;
  logic [DW-1:0] sr0, si0, sr3, si3;
  logic [15:0]   fs0, fs3;

  always #5 clk = ~clk;

  fft_frame_feeder #(.NFFT(NFFT), .FRAME_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .in_r(in_r), .in_i(in_i),
    .start_FFT(st0), .serial_in_r(sr0), .serial_in_i(si0), .busy(b0), .frames_sent(fs0));

  fft_frame_feeder #(.NFFT(NFFT), .FRAME_GAP(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(rdy3), .in_r(in_r), .in_i(in_i),
    .start_FFT(st3), .serial_in_r(sr3), .serial_in_i(si3), .busy(b3), .frames_sent(fs3));

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] i;
    logic          start;
    logic          last;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;
  int cyc = 0;
  int tests = 0, fails = 0;
  int acc0 = 0, acc3 = 0, fexp0 = 0, fexp3 = 0;
  int run0 = 0, run3 = 0, maxrun0 = 0, maxrun3 = 0;
  int idle3 = 0, lastgap3 = -1;
  bit ended3 = 1'b0;
  int stall0 = 0, last_acc_edge = 0, start_cyc0 = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (b0) begin
      if (q0.size() == 0) check("dut0 unexpected sample", 64'd1, 64'd0);
      else begin
        e0 = q0.pop_front();
        check("dut0 serial_in_r", 64'(sr0), 64'(e0.r));
        check("dut0 serial_in_i", 64'(si0), 64'(e0.i));
        check("dut0 start_FFT", 64'(st0), 64'(e0.start));
        if (e0.last) begin
          fexp0++;
          check("dut0 frames_sent", 64'(fs0), 64'(fexp0 % 65536));
        end
      end
      run0++;
      if (run0 > maxrun0) maxrun0 = run0;
      if (st0 && start_cyc0 < 0) start_cyc0 = cyc;
    end else begin
      check("dut0 idle outputs", {31'b0, st0, sr0 | si0}, 64'd0);
      run0 = 0;
    end
  end

  always @(negedge clk) begin
    if (b3) begin
      if (q3.size() == 0) check("dut3 unexpected sample", 64'd1, 64'd0);
      else begin
        e3 = q3.pop_front();
        check("dut3 serial_in_r", 64'(sr3), 64'(e3.r));
        check("dut3 serial_in_i", 64'(si3), 64'(e3.i));
        check("dut3 start_FFT", 64'(st3), 64'(e3.start));
        if (st3 && ended3) begin
          lastgap3 = idle3;
          ended3 = 1'b0;
        end
        if (e3.last) begin
          fexp3++;
          check("dut3 frames_sent", 64'(fs3), 64'(fexp3 % 65536));
          ended3 = 1'b1;
          idle3 = 0;
        end
      end
      run3++;
      if (run3 > maxrun3) maxrun3 = run3;
    end else begin
      check("dut3 idle outputs", {31'b0, st3, sr3 | si3}, 64'd0);
      run3 = 0;
      if (ended3) idle3++;
    end
  end

  // Caller sits at a falling edge; reset is applied on the next rising edge.
  task automatic do_reset();
    #1;
    rst = 1'b1; v0 = 1'b0; v3 = 1'b0;
    q0.delete(); q3.delete();
    acc0 = 0; acc3 = 0; fexp0 = 0; fexp3 = 0;
    ended3 = 1'b0; lastgap3 = -1;
    @(negedge clk);
    check("reset dut0 outputs", {29'b0, st0, b0, rdy0, sr0 | si0}, {29'b0, 3'b001, 32'd0});
    check("reset dut3 outputs", {29'b0, st3, b3, rdy3, sr3 | si3}, {29'b0, 3'b001, 32'd0});
    check("reset frames_sent", {32'b0, fs0, fs3}, 64'd0);
    #1 rst = 1'b0;
  endtask

  // mode 0: continuous valid, 1: toggling valid, 2: random valid
  task automatic send(input int d, input int nsamp, input int mode, input bit ramp);
    int sent = 0;
    int guard = 0;
    bit vld;
    bit rdy;
    exp_t e;
    while (sent < nsamp && guard < 20000) begin
      @(negedge clk);
      vld = (mode == 0) ? 1'b1 : (mode == 1) ? (guard % 2 == 0) : 1'(($urandom_range(0, 1)));
      in_r = ramp ? DW'(sent) : DW'($urandom);
      in_i = ramp ? DW'(-sent) : DW'($urandom);
      v0 = (d == 0) && vld;
      v3 = (d == 3) && vld;
      rdy = (d == 0) ? rdy0 : rdy3;
      if (vld && !rdy && d == 0) stall0++;
      if (vld && rdy) begin
        e.r = in_r;
        e.i = in_i;
        if (d == 0) begin
          e.start = (acc0 % NFFT == 0);
          e.last  = (acc0 % NFFT == NFFT - 1);
          q0.push_back(e);
          acc0++;
        end else begin
          e.start = (acc3 % NFFT == 0);
          e.last  = (acc3 % NFFT == NFFT - 1);
          q3.push_back(e);
          acc3++;
        end
        sent++;
        last_acc_edge = cyc + 1;
      end
      guard++;
    end
    if (sent < nsamp) check("send timeout", 64'(sent), 64'(nsamp));
    @(negedge clk);
    v0 = 1'b0;
    v3 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q3.size() != 0 || b0 || b3) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain queues empty", 64'(q0.size() + q3.size()), 64'd0);
  endtask

  initial begin
    int n;
    @(negedge clk);
    do_reset();

    // 1: single ramp frame, latency and no back-pressure
    stall0 = 0; start_cyc0 = -1;
    send(0, NFFT, 0, 1'b1);
    drain();
    check("t1 start latency", 64'(start_cyc0 - last_acc_edge), 64'd2);
    check("t1 no stall", 64'(stall0), 64'd0);
    check("t1 frames_sent", 64'(fs0), 64'd1);

    // 2: two frames back-to-back
    @(negedge clk); do_reset();
    maxrun0 = 0;
    send(0, 2 * NFFT, 0, 1'b0);
    drain();
    check("t2 contiguous busy", 64'(maxrun0), 64'(2 * NFFT));
    check("t2 frames_sent", 64'(fs0), 64'd2);

    // 3: three frames at full rate, one stall cycle while both banks are full
    @(negedge clk); do_reset();
    stall0 = 0;
    send(0, 3 * NFFT, 0, 1'b0);
    drain();
    check("t3 stall cycles", 64'(stall0), 64'd1);
    check("t3 frames_sent", 64'(fs0), 64'd3);

    // 4: toggling valid still yields a gap-free frame
    @(negedge clk); do_reset();
    maxrun0 = 0;
    send(0, NFFT, 1, 1'b0);
    drain();
    check("t4 gap-free frame", 64'(maxrun0), 64'(NFFT));

    // 5: reset while sample 60 is driven
    @(negedge clk); do_reset();
    send(0, NFFT, 0, 1'b0);
    n = 0;
    while (!st0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("t5 start seen", 64'(st0), 64'd1);
    repeat (60) @(negedge clk);
    #1;
    check("t5 samples before reset", 64'(q0.size()), 64'(NFFT - 61));
    do_reset();
    send(0, NFFT, 2, 1'b0);
    drain();
    check("t5 frames after reset", 64'(fs0), 64'd1);

    // 6: FRAME_GAP=3 between two queued frames
    @(negedge clk); do_reset();
    maxrun3 = 0;
    send(3, 2 * NFFT, 0, 1'b0);
    drain();
    check("t6 gap cycles", 64'(lastgap3), 64'd3);
    check("t6 frame length", 64'(maxrun3), 64'(NFFT));
    check("t6 frames_sent", 64'(fs3), 64'd2);

    // random valid traffic on both instances
    @(negedge clk); do_reset();
    send(0, 3 * NFFT, 2, 1'b0);
    send(3, 2 * NFFT, 2, 1'b0);
    drain();
    check("rand dut0 frames", 64'(fs0), 64'd3);
    check("rand dut3 frames", 64'(fs3), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
